// File: rtl/gb_pkg.sv
// Shared ghostbus host definitions: FSM encoding, read-latency limits, counter width.
package gb_pkg;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 7;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_RWAIT  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Out-of-range latencies are pulled into the legal window.
  function automatic int unsigned clamp_lat(input int unsigned lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

  // Counter only needs to hold lat-1.
  function automatic int unsigned lat_cnt_w(input int unsigned lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/gb_lat_cnt.sv
// Read-latency down-counter: load lat-1, count down while enabled, terminal count at zero.
module gb_lat_cnt
  import gb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc_c
);

  localparam int unsigned   CW       = lat_cnt_w(RD_LAT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(RD_LAT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_tc_c = (r_cnt == '0);

endmodule

// File: rtl/gb_host.sv
// Ghostbus host: accepts one command at a time, issues a one-cycle strobe,
// posts writes and returns read data after a fixed peripheral latency.
module gb_host
  import gb_pkg::*;
#(
  parameter int unsigned AW     = 24,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [DW-1:0]    cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_rdata,
  output logic [AW-1:0]    gb_addr,
  output logic [DW-1:0]    gb_dout,
  output logic             gb_we,
  output logic             gb_re,
  input  logic [DW-1:0]    gb_din,
  output logic             busy,
  output logic [CNT_W-1:0] n_wr,
  output logic [CNT_W-1:0] n_rd
);

  localparam int unsigned LAT = clamp_lat(RD_LAT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [DW-1:0]    r_rsp_rdata;
  logic [AW-1:0]    r_gb_addr;
  logic [DW-1:0]    r_gb_dout;
  logic             r_gb_we;
  logic             r_gb_re;
  logic             r_busy;
  logic [CNT_W-1:0] r_n_wr;
  logic [CNT_W-1:0] r_n_rd;
  logic             w_hs;
  logic             w_lat_load;
  logic             w_lat_en;
  logic             w_lat_tc;
  logic             w_capture;
  logic             w_rsp_done;

  gb_lat_cnt #(.RD_LAT(LAT)) u_lat_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_lat_load),
    .i_en   (w_lat_en),
    .o_tc_c (w_lat_tc)
  );

  // Next-state and per-cycle control.
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = cmd_valid && r_cmd_ready;
    w_lat_load  = 1'b0;
    w_lat_en    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) w_state_nxt = ST_STROBE;
      end
      ST_STROBE: begin
        if (r_gb_we) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RWAIT;
          w_lat_load  = 1'b1;
        end
      end
      ST_RWAIT: begin
        w_lat_en = 1'b1;
        if (w_lat_tc) begin
          w_state_nxt = ST_RESP;
          w_capture   = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
          w_rsp_done  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs; strobes are set at the handshake edge so they land in STROBE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_gb_addr   <= '0;
      r_gb_dout   <= '0;
      r_gb_we     <= 1'b0;
      r_gb_re     <= 1'b0;
      r_busy      <= 1'b0;
      r_n_wr      <= '0;
      r_n_rd      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      r_gb_we     <= w_hs && cmd_we;
      r_gb_re     <= w_hs && !cmd_we;
      if (w_hs) begin
        r_gb_addr <= cmd_addr;
        r_gb_dout <= cmd_wdata;
      end
      if (w_hs && cmd_we) r_n_wr <= r_n_wr + CNT_W'(1);
      if (w_capture)      r_rsp_rdata <= gb_din;
      if (w_rsp_done)     r_n_rd <= r_n_rd + CNT_W'(1);
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign gb_addr   = r_gb_addr;
  assign gb_dout   = r_gb_dout;
  assign gb_we     = r_gb_we;
  assign gb_re     = r_gb_re;
  assign busy      = r_busy;
  assign n_wr      = r_n_wr;
  assign n_rd      = r_n_rd;

endmodule

// File: tb/tb_gb_host.sv
// Directed + random bench for gb_host with a fixed-latency ghostbus peripheral model.
module tb_gb_host;

  localparam int unsigned AW     = 24;
  localparam int unsigned DW     = 32;
  localparam int unsigned RD_LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_dout;
  logic          gb_we;
  logic          gb_re;
  logic [DW-1:0] gb_din;
  logic          busy;
  logic [15:0]   n_wr;
  logic [15:0]   n_rd;

  int            n_checks = 0;
  int            n_errors = 0;
  logic          mon_en   = 1'b0;
  logic [DW-1:0] q[$];
  logic [15:0]   exp_wr = '0;
  logic [15:0]   exp_rd = '0;

  gb_host #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .gb_addr   (gb_addr),
    .gb_dout   (gb_dout),
    .gb_we     (gb_we),
    .gb_re     (gb_re),
    .gb_din    (gb_din),
    .busy      (busy),
    .n_wr      (n_wr),
    .n_rd      (n_rd)
  );

  always #5 clk = ~clk;

  // Peripheral: data is valid only in the cycle RD_LAT after gb_re, junk otherwise.
  logic [RD_LAT-1:0] re_pipe = '0;
  logic [31:0]       cyc     = '0;
  always @(posedge clk) begin
    cyc     <= cyc + 32'd1;
    re_pipe <= {re_pipe[RD_LAT-2:0], gb_re};
  end

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | DW'(a);
  endfunction

  assign gb_din = re_pipe[RD_LAT-1] ? model_rd(gb_addr) : (32'h0BAD_0000 ^ cyc);

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      assert (!(gb_we === 1'b1 && gb_re === 1'b1)) else begin
        n_errors++;
        $error("FAIL mutex: observed gb_we=%b gb_re=%b expected not both high", gb_we, gb_re);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command until accepted, then check the strobe cycle.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input string tag);
    logic hs;
    hs = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int k = 0; k < 64 && !hs; k++) begin
      hs = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    chk({tag, "_hs"}, DW'(hs), DW'(1));
    if (hs) begin
      chk({tag, "_we"},   DW'(gb_we),   DW'(we));
      chk({tag, "_re"},   DW'(gb_re),   DW'(!we));
      chk({tag, "_addr"}, DW'(gb_addr), DW'(a));
      chk({tag, "_dout"}, gb_dout, d);
      if (we) exp_wr = exp_wr + 16'd1;
      else    q.push_back(model_rd(a));
    end
  endtask

  // Random backpressure until the pending response is taken.
  task automatic wait_resp(input string tag);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      if (rsp_valid && rsp_ready) begin
        chk(tag, rsp_rdata, q.pop_front());
        exp_rd = exp_rd + 16'd1;
        done   = 1'b1;
      end
      step();
    end
    chk({tag, "_done"}, DW'(done), DW'(1));
  endtask

  initial begin
    int strobes;
    int bad;
    int last;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    repeat (3) step();

    chk("rst_cmd_ready", DW'(cmd_ready), '0);
    chk("rst_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_gb_we",     DW'(gb_we),     '0);
    chk("rst_gb_re",     DW'(gb_re),     '0);
    chk("rst_busy",      DW'(busy),      '0);
    chk("rst_gb_addr",   DW'(gb_addr),   '0);
    chk("rst_gb_dout",   gb_dout,        '0);
    chk("rst_rdata",     rsp_rdata,      '0);
    chk("rst_n_wr",      DW'(n_wr),      '0);
    chk("rst_n_rd",      DW'(n_rd),      '0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    step();
    chk("rel_cmd_ready", DW'(cmd_ready), DW'(1));

    // Reset while the read is waiting for data.
    issue(1'b0, 24'h000030, 32'h0, "abort");
    void'(q.pop_back());
    step();
    chk("abort_busy", DW'(busy), DW'(1));
    rst_n = 1'b0;
    step();
    chk("abort_re",        DW'(gb_re),     '0);
    chk("abort_we",        DW'(gb_we),     '0);
    chk("abort_rsp_valid", DW'(rsp_valid), '0);
    chk("abort_n_rd",      DW'(n_rd),      '0);
    rst_n = 1'b1;
    step();
    chk("abort_cmd_ready", DW'(cmd_ready), DW'(1));
    repeat (6) begin
      chk("abort_no_rsp", DW'(rsp_valid), '0);
      step();
    end
    chk("abort_n_rd_after", DW'(n_rd), '0);

    // Posted write.
    issue(1'b1, 24'h000010, 32'hDEADBEEF, "wr");
    chk("wr_busy",      DW'(busy),      DW'(1));
    chk("wr_cmd_ready", DW'(cmd_ready), '0);
    step();
    chk("wr_we_off",    DW'(gb_we),     '0);
    chk("wr_n_wr",      DW'(n_wr),      DW'(1));
    chk("wr_rsp_valid", DW'(rsp_valid), '0);
    chk("wr_idle",      DW'(cmd_ready), DW'(1));

    // Read with exact timing at RD_LAT=3.
    rsp_ready = 1'b1;
    issue(1'b0, 24'h000004, 32'h0, "rd");
    repeat (3) step();
    chk("rd_valid_early", DW'(rsp_valid), '0);
    step();
    chk("rd_valid_t5", DW'(rsp_valid), DW'(1));
    chk("rd_data", rsp_rdata, 32'hA5A50004);
    void'(q.pop_front());
    exp_rd = exp_rd + 16'd1;
    step();
    chk("rd_n_rd",      DW'(n_rd),      DW'(1));
    chk("rd_rsp_off",   DW'(rsp_valid), '0);
    chk("rd_cmd_ready", DW'(cmd_ready), DW'(1));

    // Backpressure; a competing write command must be ignored.
    rsp_ready = 1'b0;
    issue(1'b0, 24'h000020, 32'h1234, "bp");
    repeat (4) step();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 24'h000077; cmd_wdata = 32'h77;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid",     DW'(rsp_valid), DW'(1));
      chk("bp_data",      rsp_rdata,      q[0]);
      chk("bp_cmd_ready", DW'(cmd_ready), '0);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("bp_data_final", rsp_rdata, q.pop_front());
    exp_rd = exp_rd + 16'd1;
    step();
    chk("bp_n_rd",      DW'(n_rd),      DW'(exp_rd));
    chk("bp_n_wr",      DW'(n_wr),      DW'(exp_wr));
    chk("bp_cmd_ready", DW'(cmd_ready), DW'(1));

    // Random mix of 1000 commands.
    for (int i = 0; i < 1000; i++) begin
      logic we;
      we = 1'($urandom_range(0, 1));
      issue(we, AW'($urandom), $urandom, "mix");
      if (!we && q.size() != 0) wait_resp("mix_rd");
      else if ($urandom_range(0, 3) == 0) step();
    end
    rsp_ready = 1'b1;
    step();
    chk("mix_n_wr",  DW'(n_wr),     DW'(exp_wr));
    chk("mix_n_rd",  DW'(n_rd),     DW'(exp_rd));
    chk("mix_q_len", DW'(q.size()), '0);

    // 65536 back-to-back writes from a clean counter.
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("wrap_start_ready", DW'(cmd_ready), DW'(1));
    chk("wrap_start_n_wr",  DW'(n_wr),      '0);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 24'h000055; cmd_wdata = 32'h5555AAAA;
    strobes = 0; bad = 0; last = -2;
    for (int i = 0; i < 131072; i++) begin
      step();
      if (gb_we) begin
        strobes++;
        if (i - last != 2) bad++;
        last = i;
      end
      if (gb_re) bad++;
      if (i == 131071) cmd_valid = 1'b0;
    end
    chk("wrap_strobes", DW'(strobes), DW'(65536));
    chk("wrap_spacing", DW'(bad),     '0);
    repeat (2) step();
    chk("wrap_n_wr",   DW'(n_wr),  '0);
    chk("wrap_we_off", DW'(gb_we), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gb_host.md
GB_HOST -- requirements
Module: gb_host

Interface
REQ-001 The block SHALL have parameter AW, default 24, meaning the ghostbus address width in bits.
REQ-002 The block SHALL have parameter DW, default 32, meaning the ghostbus data width in bits.
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning the cycles from the gb_re strobe to valid gb_din; legal range 1..7.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 cmd_we  input  1  1 = write command, 0 = read command.
REQ-009 cmd_addr  input  AW  target address.
REQ-010 cmd_wdata  input  DW  write data.
REQ-011 rsp_valid  output  1  read data available.
REQ-012 rsp_ready  input  1  response consumer ready.
REQ-013 rsp_rdata  output  DW  captured read data.
REQ-014 gb_addr  output  AW  ghostbus address.
REQ-015 gb_dout  output  DW  ghostbus write data (host to peripherals).
REQ-016 gb_we  output  1  one-cycle write strobe.
REQ-017 gb_re  output  1  one-cycle read strobe.
REQ-018 gb_din  input  DW  ghostbus read data (peripherals to host).
REQ-019 busy  output  1  high whenever the FSM is not in IDLE.
REQ-020 n_wr, n_rd  output  16 each  completed-write and completed-read counters; both wrap from 0xFFFF to 0.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, STROBE, RWAIT, RESP.
REQ-022 cmd_ready SHALL be high only in IDLE, so at most one transaction is outstanding.
REQ-023 On handshake in cycle T, the block SHALL register cmd_addr into gb_addr and cmd_wdata into gb_dout, and SHALL go to STROBE.
REQ-024 In STROBE (cycle T+1), the block SHALL assert gb_we=cmd_we or gb_re=!cmd_we for exactly one cycle; gb_we and gb_re SHALL never be high together.
REQ-025 A write SHALL be posted: STROBE goes to IDLE, n_wr increments at T+1, and no response is generated.
REQ-026 A read SHALL go STROBE to RWAIT; the block SHALL count RD_LAT cycles and sample gb_din into rsp_rdata at cycle T+1+RD_LAT.
REQ-027 In RESP, rsp_valid SHALL be high from cycle T+2+RD_LAT and hold, with rsp_rdata stable, until rsp_ready is high.
REQ-028 On the cycle rsp_valid && rsp_ready, n_rd SHALL increment and the FSM SHALL go to IDLE; cmd_ready SHALL be high the next cycle.
REQ-029 Minimum occupancy SHALL be 2 cycles per write and RD_LAT+3 cycles per read when rsp_ready is held high.
REQ-030 gb_addr and gb_dout SHALL hold their last value between transactions.
REQ-031 cmd_* inputs SHALL be ignored outside IDLE.
REQ-032 rsp_ready is a don't-care outside RESP.

Reset
REQ-033 When rst_n is low at a clock edge, the block SHALL set state=IDLE, cmd_ready=0 during reset, and rsp_valid, gb_we, gb_re and busy all to 0.
REQ-034 During reset, gb_addr, gb_dout, rsp_rdata, n_wr and n_rd SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL abort it: no strobe, no response and no counter increment from the aborted command.
REQ-036 cmd_ready SHALL rise in the first cycle after rst_n goes high.

Structure
REQ-037 The FSM state encoding, the RD_LAT legal range and the counter width (16) SHALL be defined in a shared package, gb_pkg.
REQ-038 The read-latency counter SHALL be a separate sub-module, gb_lat_cnt: a load/terminal-count down-counter with width derived from RD_LAT.
REQ-039 The ghostbus port bundle (gb_addr, gb_dout, gb_we, gb_re, gb_din) SHALL connect unmodified to the interposer hierarchy's bus ports.

Verification
REQ-040 Write: cmd_we=1, addr 0x000010, wdata 0xDEADBEEF -> gb_we high for one cycle at T+1 with gb_addr=0x000010 and gb_dout=0xDEADBEEF; n_wr=1; rsp_valid stays 0.
REQ-041 Read at RD_LAT=3, with a model returning 0xA5A5_0000|addr, read addr 0x000004 -> gb_re at T+1; rsp_valid at T+5 with rsp_rdata=0xA5A50004; n_rd=1.
REQ-042 Backpressure: rsp_ready held low for 10 cycles -> rsp_valid and rsp_rdata stable for the whole period, and cmd_ready stays 0.
REQ-043 Reset mid-op: rst_n low in RWAIT -> next cycle all strobes and rsp_valid are 0, n_rd is unchanged, and cmd_ready is 1 after release.
REQ-044 Wrap: 65536 back-to-back writes -> n_wr reads 0, no strobe is dropped, and the spacing is 2 cycles per write.
REQ-045 Mutual exclusion: a random mix of 1000 commands -> the assertion that gb_we and gb_re are never high together is never violated.
